// File: rtl/pipe_ctrl_2023211063.sv
// rtl/pipe_ctrl_2023211063.sv - pipeline hazard/stall/flush controller with perf counters
module pipe_ctrl_2023211063 #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_jump_i,
    input  logic [31:0]      ex_jump_addr_i,
    input  logic             ex_load_i,
    input  logic             ex_reg_we_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       id_rs1_i,
    input  logic             id_rs1_re_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs2_re_i,
    input  logic             ex_busy_i,
    input  logic             int_req_i,
    output logic             int_ack_o,
    output logic             stall_front_o,
    output logic             stall_idex_o,
    output logic             bubble_o,
    output logic [2:0]       hold_flag_o,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ID   = 3'b011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MC    = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             run_eval;

    // Next state and all control outputs; MC with busy dropped evaluates as RUN in the same cycle
    always_comb begin
        state_d       = state_q;
        int_ack_o     = 1'b0;
        stall_front_o = 1'b0;
        stall_idex_o  = 1'b0;
        bubble_o      = 1'b0;
        hold_flag_o   = HOLD_NONE;
        jump_flag_o   = 1'b0;
        jump_addr_o   = 32'd0;

        load_use = ex_load_i && ex_reg_we_i && (ex_rd_i != 5'd0) &&
                   ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                    (id_rs2_re_i && (id_rs2_i == ex_rd_i)));
        run_eval = (state_q == RUN) || ((state_q == MC) && !ex_busy_i);

        if (run_eval) begin
            state_d = RUN;
            if (int_req_i) begin
                int_ack_o   = 1'b1;
                hold_flag_o = HOLD_ID;
            end else if (ex_busy_i) begin
                stall_front_o = 1'b1;
                stall_idex_o  = 1'b1;
                state_d       = MC;
            end else if (ex_jump_i) begin
                jump_flag_o = 1'b1;
                jump_addr_o = ex_jump_addr_i;
                hold_flag_o = HOLD_ID;
                state_d     = FLUSH;
            end else if (load_use) begin
                stall_front_o = 1'b1;
                bubble_o      = 1'b1;
            end
        end else if (state_q == MC) begin
            // Multi-cycle op still running: interrupts wait, jumps and hazards are moot
            stall_front_o = 1'b1;
            stall_idex_o  = 1'b1;
            state_d       = MC;
        end else begin
            // FLUSH (and any unused encoding): kill the wrong-path fetch for one cycle
            state_d     = RUN;
            hold_flag_o = HOLD_IF;
            if (int_req_i) begin
                int_ack_o   = 1'b1;
                hold_flag_o = HOLD_ID;
            end
        end

        if (!rst) begin
            state_d       = RUN;
            int_ack_o     = 1'b0;
            stall_front_o = 1'b0;
            stall_idex_o  = 1'b0;
            bubble_o      = 1'b0;
            hold_flag_o   = HOLD_NONE;
            jump_flag_o   = 1'b0;
            jump_addr_o   = 32'd0;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_front_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (jump_flag_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_2023211063.sv
// tb/tb_pipe_ctrl_2023211063.sv - self-checking bench with behavioural model for pipe_ctrl_2023211063
module tb_pipe_ctrl_2023211063;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_load_i;
    logic        ex_reg_we_i;
    logic [4:0]  ex_rd_i;
    logic [4:0]  id_rs1_i;
    logic        id_rs1_re_i;
    logic [4:0]  id_rs2_i;
    logic        id_rs2_re_i;
    logic        ex_busy_i;
    logic        int_req_i;
    logic        int_ack_o;
    logic        stall_front_o;
    logic        stall_idex_o;
    logic        bubble_o;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [W-1:0] stall_cnt_o;
    logic [W-1:0] flush_cnt_o;

    int checks = 0;
    int failures = 0;

    pipe_ctrl_2023211063 #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst),
        .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i),
        .ex_load_i(ex_load_i), .ex_reg_we_i(ex_reg_we_i), .ex_rd_i(ex_rd_i),
        .id_rs1_i(id_rs1_i), .id_rs1_re_i(id_rs1_re_i),
        .id_rs2_i(id_rs2_i), .id_rs2_re_i(id_rs2_re_i),
        .ex_busy_i(ex_busy_i), .int_req_i(int_req_i),
        .int_ack_o(int_ack_o), .stall_front_o(stall_front_o),
        .stall_idex_o(stall_idex_o), .bubble_o(bubble_o),
        .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o),
        .jump_addr_o(jump_addr_o), .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model history: did the last cycle issue a redirect, did it stall for a busy EX op
    logic         m_after_jump = 1'b0;
    logic         m_in_busy    = 1'b0;
    logic [W-1:0] m_scnt       = '0;
    logic [W-1:0] m_fcnt       = '0;

    typedef struct packed {
        logic        ack;
        logic        sf;
        logic        si;
        logic        bub;
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] addr;
    } exp_t;

    function automatic exp_t predict();
        exp_t e;
        logic lu;
        e = '0;
        lu = ex_load_i && ex_reg_we_i && (ex_rd_i != 0) &&
             ((id_rs1_re_i && id_rs1_i == ex_rd_i) || (id_rs2_re_i && id_rs2_i == ex_rd_i));
        if (!rst) begin
            e = '0;
        end else if (m_after_jump) begin
            e.hold = int_req_i ? 3'd3 : 3'd2;
            e.ack  = int_req_i;
        end else if (ex_busy_i && (m_in_busy || !int_req_i)) begin
            e.sf = 1'b1;
            e.si = 1'b1;
        end else if (int_req_i) begin
            e.ack  = 1'b1;
            e.hold = 3'd3;
        end else if (ex_jump_i) begin
            e.jf   = 1'b1;
            e.addr = ex_jump_addr_i;
            e.hold = 3'd3;
        end else if (lu) begin
            e.sf  = 1'b1;
            e.bub = 1'b1;
        end
        return e;
    endfunction

    // Advance the model on each clock edge
    always @(posedge clk) begin
        exp_t e;
        e = predict();
        if (!rst) begin
            m_after_jump <= 1'b0;
            m_in_busy    <= 1'b0;
            m_scnt       <= '0;
            m_fcnt       <= '0;
        end else begin
            m_after_jump <= e.jf;
            m_in_busy    <= e.si;
            if (e.sf && m_scnt != '1) m_scnt <= m_scnt + 1'b1;
            if (e.jf && m_fcnt != '1) m_fcnt <= m_fcnt + 1'b1;
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        exp_t e;
        e = predict();
        check("m_int_ack", {31'd0, int_ack_o}, {31'd0, e.ack});
        check("m_stall_front", {31'd0, stall_front_o}, {31'd0, e.sf});
        check("m_stall_idex", {31'd0, stall_idex_o}, {31'd0, e.si});
        check("m_bubble", {31'd0, bubble_o}, {31'd0, e.bub});
        check("m_hold", {29'd0, hold_flag_o}, {29'd0, e.hold});
        check("m_jump_flag", {31'd0, jump_flag_o}, {31'd0, e.jf});
        check("m_jump_addr", jump_addr_o, e.addr);
        check("m_stall_cnt", {28'd0, stall_cnt_o}, rst ? {28'd0, m_scnt} : 32'd0);
        check("m_flush_cnt", {28'd0, flush_cnt_o}, rst ? {28'd0, m_fcnt} : 32'd0);
    end

    task automatic idle();
        ex_jump_i = 0; ex_jump_addr_i = 32'h0; ex_load_i = 0; ex_reg_we_i = 0;
        ex_rd_i = 0; id_rs1_i = 0; id_rs1_re_i = 0; id_rs2_i = 0; id_rs2_re_i = 0;
        ex_busy_i = 0; int_req_i = 0;
    endtask

    task automatic load_use_stim(input logic [4:0] rd);
        idle();
        ex_load_i = 1; ex_reg_we_i = 1; ex_rd_i = rd; id_rs2_re_i = 1; id_rs2_i = 5;
    endtask

    // Advance to just after the next rising edge, where inputs are changed
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        ex_jump_i = 1; ex_jump_addr_i = 32'hdead_beef; ex_busy_i = 1; int_req_i = 1;
        #2;
        check("rst_jump_flag", {31'd0, jump_flag_o}, 32'd0);
        check("rst_hold", {29'd0, hold_flag_o}, 32'd0);
        check("rst_jump_addr", jump_addr_o, 32'd0);
        check("rst_stalls", {30'd0, stall_front_o, stall_idex_o}, 32'd0);
        check("rst_int_ack", {31'd0, int_ack_o}, 32'd0);
        step(); step();
        idle();
        rst = 1'b1;

        // load-use on x5
        load_use_stim(5'd5);
        #2;
        check("lu_stall_front", {31'd0, stall_front_o}, 32'd1);
        check("lu_bubble", {31'd0, bubble_o}, 32'd1);
        check("lu_stall_idex", {31'd0, stall_idex_o}, 32'd0);
        step();
        idle();
        #2;
        check("lu_stall_cnt", {28'd0, stall_cnt_o}, 32'd1);

        // load-use against x0 is not a hazard
        load_use_stim(5'd0);
        #2;
        check("x0_outputs", {int_ack_o, stall_front_o, stall_idex_o, bubble_o, hold_flag_o, jump_flag_o}, 32'd0);
        step();

        // redirect and one flush cycle
        idle();
        ex_jump_i = 1; ex_jump_addr_i = 32'h0000_0100;
        #2;
        check("jmp_c0_flag", {31'd0, jump_flag_o}, 32'd1);
        check("jmp_c0_addr", jump_addr_o, 32'h100);
        check("jmp_c0_hold", {29'd0, hold_flag_o}, 32'd3);
        step();
        idle();
        #2;
        check("jmp_c1_hold", {29'd0, hold_flag_o}, 32'd2);
        check("jmp_c1_flag", {31'd0, jump_flag_o}, 32'd0);
        step();
        #2;
        check("jmp_c2_hold", {29'd0, hold_flag_o}, 32'd0);
        check("jmp_flush_cnt", {28'd0, flush_cnt_o}, 32'd1);

        // 4-cycle busy with interrupt arriving in busy cycle 2
        for (int c = 1; c <= 4; c++) begin
            step();
            idle();
            ex_busy_i = 1;
            int_req_i = (c >= 2);
            #2;
            check("mc_stalls", {30'd0, stall_front_o, stall_idex_o}, 32'd3);
            check("mc_int_ack", {31'd0, int_ack_o}, 32'd0);
        end
        step();
        idle();
        int_req_i = 1;
        #2;
        check("mc_end_ack", {31'd0, int_ack_o}, 32'd1);
        check("mc_end_hold", {29'd0, hold_flag_o}, 32'd3);
        check("mc_end_stall", {31'd0, stall_front_o}, 32'd0);
        check("mc_stall_cnt", {28'd0, stall_cnt_o}, 32'd5);

        // interrupt beats jump
        step();
        idle();
        int_req_i = 1; ex_jump_i = 1; ex_jump_addr_i = 32'h40;
        #2;
        check("sim_ack", {31'd0, int_ack_o}, 32'd1);
        check("sim_hold", {29'd0, hold_flag_o}, 32'd3);
        check("sim_jump_flag", {31'd0, jump_flag_o}, 32'd0);
        step();
        idle();
        #2;
        check("sim_stays_run", {29'd0, hold_flag_o}, 32'd0);

        // saturation of the stall counter
        for (int c = 0; c < 12; c++) begin
            step();
            load_use_stim(5'd5);
        end
        step();
        idle();
        #2;
        check("sat_stall_cnt", {28'd0, stall_cnt_o}, 32'd15);
        load_use_stim(5'd5);
        step();
        idle();
        #2;
        check("sat_stall_hold", {28'd0, stall_cnt_o}, 32'd15);

        // reset in the middle of a flush
        ex_jump_i = 1; ex_jump_addr_i = 32'h200;
        step();
        idle();
        #2;
        check("fl_hold_pre", {29'd0, hold_flag_o}, 32'd2);
        rst = 1'b0;
        #1;
        check("fl_rst_hold", {29'd0, hold_flag_o}, 32'd0);
        check("fl_rst_cnts", {24'd0, stall_cnt_o, flush_cnt_o}, 32'd0);
        step();
        rst = 1'b1;
        ex_jump_i = 1; ex_jump_addr_i = 32'h300;
        #2;
        check("post_rst_run", {31'd0, jump_flag_o}, 32'd1);
        check("post_rst_hold", {29'd0, hold_flag_o}, 32'd3);

        // randomized traffic with occasional resets, checked by the model
        for (int c = 0; c < 3000; c++) begin
            step();
            rst            = ($urandom_range(0, 149) != 0);
            ex_jump_i      = ($urandom_range(0, 4) == 0);
            ex_jump_addr_i = $urandom;
            ex_load_i      = $urandom_range(0, 1);
            ex_reg_we_i    = $urandom_range(0, 1);
            ex_rd_i        = 5'($urandom_range(0, 3));
            id_rs1_i       = 5'($urandom_range(0, 3));
            id_rs1_re_i    = $urandom_range(0, 1);
            id_rs2_i       = 5'($urandom_range(0, 3));
            id_rs2_re_i    = $urandom_range(0, 1);
            ex_busy_i      = ex_busy_i ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            int_req_i      = ($urandom_range(0, 5) == 0);
        end
        step();
        idle();
        rst = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_2023211063.md
PIPE_CTRL_2023211063 -- requirements
Module: pipe_ctrl_2023211063

Interface
REQ-001 SHALL have one parameter: CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have one clock and an asynchronous, active-low reset. Ports are clk and rst.
REQ-003 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ex_jump_i  in  1  EX-stage redirect request
- ex_jump_addr_i  in  32  redirect target
- ex_load_i  in  1  EX instruction is a load
- ex_reg_we_i  in  1  EX instruction writes a GPR
- ex_rd_i  in  5  EX destination register
- id_rs1_i  in  5  ID source register 1
- id_rs1_re_i  in  1  ID reads rs1
- id_rs2_i  in  5  ID source register 2
- id_rs2_re_i  in  1  ID reads rs2
- ex_busy_i  in  1  multi-cycle EX operation in progress
- int_req_i  in  1  interrupt controller requests a pipeline hold
- int_ack_o  out  1  hold granted this cycle
- stall_front_o  out  1  freeze PC and IF/ID
- stall_idex_o  out  1  freeze ID/EX; drives the ID/EX stall_flag_i
- bubble_o  out  1  load ID/EX with NOP next edge
- hold_flag_o  out  3  flush level: None=000, Pc=001, If=010, Id=011
- jump_flag_o  out  1  redirect PC
- jump_addr_o  out  32  PC redirect target
- stall_cnt_o  out  CNT_W  cycles with stall_front_o=1
- flush_cnt_o  out  CNT_W  redirects issued

Function
REQ-004 SHALL implement the FSM states RUN, MC and FLUSH. All control outputs SHALL be combinational from state and inputs. State and counters SHALL be registered on posedge clk.
REQ-005 SHALL define load-use as: ex_load_i & ex_reg_we_i & ex_rd_i!=0 & ((id_rs1_re_i & id_rs1_i==ex_rd_i) | (id_rs2_re_i & id_rs2_i==ex_rd_i)).
REQ-006 SHALL evaluate RUN with the following priority (first match wins):
- int_req_i: int_ack_o=1, hold_flag_o=011; jump and load-use are suppressed; stay in RUN.
- ex_busy_i: stall_front_o=1, stall_idex_o=1; next state MC.
- ex_jump_i: jump_flag_o=1, jump_addr_o=ex_jump_addr_i, hold_flag_o=011; next state FLUSH.
- load-use: stall_front_o=1, bubble_o=1; stay in RUN.
REQ-007 In MC with ex_busy_i=1: stall_front_o=1 and stall_idex_o=1. int_req_i SHALL be deferred (int_ack_o=0), and ex_jump_i and load-use SHALL be ignored.
REQ-008 In MC with ex_busy_i=0: outputs and next state SHALL follow the RUN rules in the same cycle, so no extra stall cycle is added.
REQ-009 FLUSH SHALL last exactly one cycle: hold_flag_o=010 (kill the wrong-path fetch in flight), stall outputs 0, jump_flag_o=0, ex_busy_i and load-use ignored; next state RUN.
REQ-010 If int_req_i=1 in FLUSH: int_ack_o=1 and hold_flag_o=011, which overrides 010; next state RUN.
REQ-011 When an output is not driven by the rules above it SHALL be 0; jump_addr_o SHALL be 0 whenever jump_flag_o=0.
REQ-012 stall_idex_o=1 SHALL never coincide with bubble_o=1. stall_front_o=1 SHALL never coincide with jump_flag_o=1.
REQ-013 stall_cnt_o SHALL increment by 1 each cycle stall_front_o=1. flush_cnt_o SHALL increment by 1 each cycle jump_flag_o=1. Both SHALL saturate at all-ones with no wrap.
REQ-014 There SHALL be zero latency from input to control output. A single-cycle ex_busy_i pulse in RUN SHALL produce exactly one stall cycle.

Reset
REQ-015 rst=0 SHALL immediately, with no clock, force state RUN and stall_cnt_o=flush_cnt_o=0.
REQ-016 While rst=0, all control outputs SHALL be 0 regardless of inputs: int_ack_o, stall_front_o, stall_idex_o, bubble_o, jump_flag_o=0; hold_flag_o=000; jump_addr_o=0.
REQ-017 Reset asserted mid-MC or mid-FLUSH SHALL abandon the operation. After release, the first cycle SHALL evaluate as RUN.

Verification
REQ-018 The bench SHALL cover load-use: ex_load_i=1, ex_reg_we_i=1, ex_rd_i=5, id_rs2_re_i=1, id_rs2_i=5 -> stall_front_o=1, bubble_o=1, stall_idex_o=0, stall_cnt_o +1.
REQ-019 The bench SHALL cover load-use with x0: same stimulus with ex_rd_i=0 -> no stall, all outputs 0.
REQ-020 The bench SHALL cover a redirect: ex_jump_i=1, addr=0x0000_0100 in RUN -> cycle 0: jump_flag_o=1, jump_addr_o=0x100, hold=011; cycle 1: hold=010, jump_flag_o=0; cycle 2: hold=000; flush_cnt_o=1.
REQ-021 The bench SHALL cover a multi-cycle op with interrupt: ex_busy_i high 4 cycles and int_req_i rising in busy cycle 2 -> both stalls=1 for 4 cycles, int_ack_o=0 for cycles 2-4; int_ack_o=1 with hold=011 in the cycle ex_busy_i falls.
REQ-022 The bench SHALL cover simultaneous requests: int_req_i=1 with ex_jump_i=1 in RUN -> int_ack_o=1, hold=011, jump_flag_o=0, state stays RUN.
REQ-023 The bench SHALL cover saturation and reset: preload stall_cnt_o to all-ones, then stall -> value holds. rst=0 mid-FLUSH -> hold=000 immediately; after release, state RUN and counters 0.
